onex2_demux: RTL and testbench
==============================

ONEX2_DEMUX -- requirements
Module: onex2_demux

Interface
REQ-001 The parameter shall be DATA_WIDTH, default 4, meaning width of every data port.
REQ-002 The parameter shall be CNT_WIDTH, default 8, meaning width of each per-channel beat counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_data, input, DATA_WIDTH: upstream beat.
REQ-006 Port in_valid, input, 1: upstream beat present.
REQ-007 Port in_ready, output, 1: block accepts the beat this cycle.
REQ-008 Port sel, input, 1: destination when mode=0; 0 is channel A, 1 is channel B.
REQ-009 Port mode, input, 1: 0 is steer by sel, 1 is alternate A,B,A,B.
REQ-010 Ports a_data/b_data, output, DATA_WIDTH: channel heads.
REQ-011 Ports a_valid/b_valid, output, 1: channel head valid.
REQ-012 Ports a_ready/b_ready, input, 1: downstream accepts channel head.
REQ-013 Ports a_count/b_count, output, CNT_WIDTH: beats accepted into each channel.

Function
REQ-014 Transfer rule: a beat is accepted when in_valid and in_ready are both 1 at a clock edge; output transfer occurs when x_valid and x_ready are both 1.
REQ-015 Destination: mode=0 uses sel in the same cycle; mode=1 uses the alternate pointer.
REQ-016 Alternate pointer states: PTR_A and PTR_B; reset to PTR_A; toggles only on an accepted beat while mode=1; it holds in mode=0 and across mode changes.
REQ-017 Each channel has a 2-entry FIFO; in_ready = destination FIFO not full; in_ready shall not depend combinationally on a_ready or b_ready.
REQ-018 in_ready shall be independent of in_valid; the non-selected channel's fullness has no effect on in_ready.
REQ-019 Latency: an accepted beat appears at the head of an empty channel with x_valid=1 on the cycle after acceptance.
REQ-020 Ordering: each channel delivers its beats in acceptance order; no beat is dropped or duplicated.
REQ-021 A full FIFO refuses a push even if it pops in the same cycle.
REQ-022 A FIFO with 1 entry that receives a push and a pop in the same cycle stays at 1 entry, and the new beat becomes the head.
REQ-023 When a FIFO is empty, x_valid=0 and x_data holds the last popped value (0 after reset).
REQ-024 The two channels pop independently; a stall on one shall not block beats destined for the other.
REQ-025 x_count increments by 1 on each accepted beat to channel x and wraps from 2^CNT_WIDTH-1 to 0.
REQ-026 x_valid and x_data shall remain stable while x_valid=1 and x_ready=0.

Reset
REQ-027 rst=1 at an edge shall empty both FIFOs, clear a_count/b_count and data registers to 0, and set the pointer to PTR_A.
REQ-028 After reset, a_valid=b_valid=0 and in_ready=1.
REQ-029 During reset, a beat presented upstream is discarded, not counted, and mid-operation contents are lost.

Structure
REQ-030 Package onex2_demux_pkg shall hold CH_A=0, CH_B=1, FIFO_DEPTH=2, and the pointer state encoding.
REQ-031 Each channel shall instantiate sub-module demux_fifo2, a parameterised 2-entry FIFO with push/pop/full/empty/head; the demux top holds only steering, pointer and counters.

Verification
REQ-032 Reset, then mode=0, sel=0, in_data=0x5 for 1 cycle with a_ready=1 -> next cycle a_valid=1, a_data=0x5, a_count=1, b_valid=0.
REQ-033 mode=1, stream 0x1,0x2,0x3,0x4 back-to-back with both ready=1 -> A receives 0x1,0x3 and B receives 0x2,0x4; a_count=b_count=2.
REQ-034 mode=0, sel=1, b_ready=0, 3 beats -> beats 1-2 accepted, in_ready=0 on the third; switching to sel=0 -> in_ready=1 and A accepts.
REQ-035 With B holding 1 entry, assert b_ready=1 and push to B in the same cycle -> b_valid stays 1, the count of held entries stays 1, and the new data is the head next cycle.
REQ-036 Push 256 beats to A -> a_count=0 after wrap and the 257th beat gives a_count=1.
REQ-037 mode=1, pointer at PTR_B, pulse rst=1 with in_valid=1 -> FIFOs empty, counts 0, the next accepted beat goes to A.

Source files
------------

// File: rtl/onex2_demux_pkg.sv
// Shared constants and the alternate-pointer state encoding for the 1-to-2 demux.
package onex2_demux_pkg;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_state_e;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO with a registered head; the head keeps the last popped value when empty.
module demux_fifo2
  import onex2_demux_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [FIFO_CNT_W-1:0] cnt_q;
  logic [W-1:0]          head_q;
  logic [W-1:0]          tail_q;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (cnt_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + FIFO_CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - FIFO_CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase

      // Head refills from the tail when two are held, else from din on push-into-empty or push+pop.
      if (do_pop && full) begin
        head_q <= tail_q;
      end else if (do_push && (empty || do_pop)) begin
        head_q <= din;
      end

      if (do_push && !do_pop && (cnt_q == FIFO_CNT_W'(1))) begin
        tail_q <= din;
      end
    end
  end

endmodule

// File: rtl/onex2_demux.sv
// One-to-two demux: steers upstream beats to channel A or B by sel or by an alternating pointer.
module onex2_demux
  import onex2_demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sel,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [CNT_WIDTH-1:0]  a_count,
  output logic [CNT_WIDTH-1:0]  b_count
);

  ptr_state_e ptr_q;
  ptr_state_e ptr_d;
  logic       alt_dest;
  logic       dest;
  logic       accept;
  logic       a_push;
  logic       b_push;
  logic       a_full;
  logic       b_full;
  logic       a_empty;
  logic       b_empty;

  // Alternate pointer: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Alternate pointer: advances only on a beat accepted in alternate mode.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && mode) begin
      ptr_d = (ptr_q == PTR_A) ? PTR_B : PTR_A;
    end
  end

  // Alternate pointer: channel it currently designates.
  always_comb begin
    alt_dest = CH_A;
    if (ptr_q == PTR_B) begin
      alt_dest = CH_B;
    end
  end

  // Readiness looks only at the destination FIFO's fullness, never at downstream ready.
  always_comb begin
    dest     = mode ? alt_dest : sel;
    in_ready = (dest == CH_A) ? !a_full : !b_full;
    accept   = in_valid && in_ready;
    a_push   = accept && (dest == CH_A);
    b_push   = accept && (dest == CH_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (a_push) a_count <= a_count + CNT_WIDTH'(1);
      if (b_push) b_count <= b_count + CNT_WIDTH'(1);
    end
  end

  assign a_valid = !a_empty;
  assign b_valid = !b_empty;

  demux_fifo2 #(.W(DATA_WIDTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (a_push),
    .pop   (a_ready),
    .din   (in_data),
    .full  (a_full),
    .empty (a_empty),
    .head  (a_data)
  );

  demux_fifo2 #(.W(DATA_WIDTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (b_push),
    .pop   (b_ready),
    .din   (in_data),
    .full  (b_full),
    .empty (b_empty),
    .head  (b_data)
  );

endmodule

// File: tb/tb_onex2_demux.sv
// Bench for onex2_demux: queue-based channel model checked every cycle plus directed literal checks.
module tb_onex2_demux;

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          sel;
  logic          mode;
  logic [DW-1:0] a_data;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          b_ready;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  onex2_demux #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  // Behavioural model: one queue per channel, last-popped values, counts, alternate pointer.
  logic [DW-1:0] mq_a[$];
  logic [DW-1:0] mq_b[$];
  logic [DW-1:0] m_last_a = '0;
  logic [DW-1:0] m_last_b = '0;
  int            m_cnt_a  = 0;
  int            m_cnt_b  = 0;
  int            m_ptr    = 0;
  logic [DW-1:0] got_a[$];
  logic [DW-1:0] got_b[$];

  function automatic int m_dest();
    return mode ? m_ptr : int'(sel);
  endfunction

  function automatic bit m_ready();
    return (m_dest() == 0) ? (mq_a.size() < 2) : (mq_b.size() < 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq_a.delete();
      mq_b.delete();
      m_last_a = '0;
      m_last_b = '0;
      m_cnt_a  = 0;
      m_cnt_b  = 0;
      m_ptr    = 0;
    end else begin : upd
      int d;
      bit rdy;
      d   = m_dest();
      rdy = m_ready();
      if (a_ready && mq_a.size() > 0) m_last_a = mq_a.pop_front();
      if (b_ready && mq_b.size() > 0) m_last_b = mq_b.pop_front();
      if (in_valid && rdy) begin
        if (d == 0) begin
          mq_a.push_back(in_data);
          m_cnt_a = (m_cnt_a + 1) % (1 << CW);
        end else begin
          mq_b.push_back(in_data);
          m_cnt_b = (m_cnt_b + 1) % (1 << CW);
        end
        if (mode) m_ptr = 1 - m_ptr;
      end
    end
  end

  // Per-cycle comparison against the model, after inputs have settled.
  always begin
    @(negedge clk);
    #1;
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("a_valid", 32'(a_valid), 32'(mq_a.size() > 0));
      chk("b_valid", 32'(b_valid), 32'(mq_b.size() > 0));
      chk("a_data", 32'(a_data), 32'((mq_a.size() > 0) ? mq_a[0] : m_last_a));
      chk("b_data", 32'(b_data), 32'((mq_b.size() > 0) ? mq_b[0] : m_last_b));
      chk("a_count", 32'(a_count), 32'(m_cnt_a));
      chk("b_count", 32'(b_count), 32'(m_cnt_b));
      if (!rst && a_valid && a_ready) got_a.push_back(a_data);
      if (!rst && b_valid && b_ready) got_b.push_back(b_data);
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [DW-1:0] d,
                     input logic s, input logic m, input logic ar, input logic br);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = d;
    sel      = s;
    mode     = m;
    a_ready  = ar;
    b_ready  = br;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = 1'b0; mode = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    @(negedge clk);
    started = 1'b1;

    // Reset state
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_a_data", 32'(a_data), 32'd0);

    // Single steered beat to A, visible next cycle
    cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    chk("one_a_valid", 32'(a_valid), 32'd1);
    chk("one_a_data", 32'(a_data), 32'h5);
    chk("one_a_count", 32'(a_count), 32'd1);
    chk("one_b_valid", 32'(b_valid), 32'd0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    chk("empty_a_holds", 32'(a_data), 32'h5);

    // Alternate mode stream
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    got_a.delete();
    got_b.delete();
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 4'(i), 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    #2;
    chk("alt_got_a_n", 32'(got_a.size()), 32'd2);
    chk("alt_got_b_n", 32'(got_b.size()), 32'd2);
    if (got_a.size() == 2 && got_b.size() == 2) begin
      chk("alt_a0", 32'(got_a[0]), 32'h1);
      chk("alt_a1", 32'(got_a[1]), 32'h3);
      chk("alt_b0", 32'(got_b[0]), 32'h2);
      chk("alt_b1", 32'(got_b[1]), 32'h4);
    end
    chk("alt_a_count", 32'(a_count), 32'd2);
    chk("alt_b_count", 32'(b_count), 32'd2);

    // Stalled B fills; A still accepts
    cyc(1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    chk("bfull_in_ready", 32'(in_ready), 32'd0);
    cyc(1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("a_open_in_ready", 32'(in_ready), 32'd1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("a_got_9", 32'(a_data), 32'h9);
    chk("b_stall_head", 32'(b_data), 32'h7);

    // B at one entry: push and pop together
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    chk("pp_pre_head", 32'(b_data), 32'h8);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("pp_b_valid", 32'(b_valid), 32'd1);
    chk("pp_b_head", 32'(b_data), 32'hA);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("pp_one_entry", 32'(b_valid), 32'd0);
    chk("pp_last_popped", 32'(b_data), 32'hA);

    // Counter wrap on A
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 256; i++) cyc(1'b0, 1'b1, 4'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("wrap_a_count", 32'(a_count), 32'd0);
    cyc(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("wrap_257", 32'(a_count), 32'd1);

    // Reset with pointer at B and a beat presented
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("ptrb_a_data", 32'(a_data), 32'h6);
    cyc(1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("rst2_a_valid", 32'(a_valid), 32'd0);
    chk("rst2_b_valid", 32'(b_valid), 32'd0);
    chk("rst2_a_count", 32'(a_count), 32'd0);
    chk("rst2_b_count", 32'(b_count), 32'd0);
    cyc(1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("rst2_to_a", 32'(a_valid), 32'd1);
    chk("rst2_a_data", 32'(a_data), 32'hC);
    chk("rst2_b_empty", 32'(b_valid), 32'd0);

    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
